// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port state SRAM between the layer sequencer (priority) and a host port.
// Optional macro STARVE_GUARD_EN: a starved host preempts the sequencer for one access per episode.
module mem_port_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 64,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          seq_en,
    input  logic          seq_we,
    input  logic [AW-1:0] seq_addr,
    input  logic [DW-1:0] seq_wdata,
    output logic [DW-1:0] seq_rdata,
    output logic          seq_rvalid,
    output logic          seq_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          host_starved,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [1:0]    ST_IDLE    = 2'd0;
    localparam logic [1:0]    ST_SEQ     = 2'd1;
    localparam logic [1:0]    ST_HOST    = 2'd2;
    localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    // owner_q doubles as the read-owner tag: it names who used the SRAM last cycle
    logic [1:0]    owner_q, owner_d;
    logic          rd_pend_q, rd_pend_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          starved_q, starved_d;
    logic [DW-1:0] seq_hold_q, host_hold_q;
    logic          force_host;
    logic          grant_seq;
    logic          grant_host;

`ifdef STARVE_GUARD_EN
    assign force_host = host_req && (wait_q >= MAX_WAIT_C);
`else
    assign force_host = 1'b0;
`endif

    assign grant_seq  = !reset && seq_en && !force_host;
    assign grant_host = !reset && host_req && (!seq_en || force_host);
    assign seq_stall  = !reset && seq_en && force_host;
    assign host_ack   = grant_host;

    always_comb begin
        mem_en    = grant_seq || grant_host;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_seq) begin
            mem_we    = seq_we;
            mem_addr  = seq_addr;
            mem_wdata = seq_wdata;
        end else if (grant_host) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Returned data is gated during reset so a read in flight never surfaces
    assign seq_rvalid   = !reset && rd_pend_q && (owner_q == ST_SEQ);
    assign host_rvalid  = !reset && rd_pend_q && (owner_q == ST_HOST);
    assign seq_rdata    = reset ? '0 : (seq_rvalid ? mem_rdata : seq_hold_q);
    assign host_rdata   = reset ? '0 : (host_rvalid ? mem_rdata : host_hold_q);
    assign host_starved = !reset && starved_q;

    always_comb begin
        owner_d   = ST_IDLE;
        rd_pend_d = 1'b0;
        wait_d    = wait_q;
        if (grant_seq) begin
            owner_d   = ST_SEQ;
            rd_pend_d = !seq_we;
        end else if (grant_host) begin
            owner_d   = ST_HOST;
            rd_pend_d = !host_we;
        end
        if (!host_req || grant_host) begin
            wait_d = '0;
        end else if (wait_q != CNT_MAX) begin
            wait_d = wait_q + CW'(1);
        end
        starved_d = (wait_d >= MAX_WAIT_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= ST_IDLE;
            rd_pend_q   <= 1'b0;
            wait_q      <= '0;
            starved_q   <= 1'b0;
            seq_hold_q  <= '0;
            host_hold_q <= '0;
        end else begin
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
            wait_q    <= wait_d;
            starved_q <= starved_d;
            if (seq_rvalid) begin
                seq_hold_q <= mem_rdata;
            end
            if (host_rvalid) begin
                host_hold_q <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level model with its own shadow memory.
module tb_mem_port_arbiter;
    localparam int AW       = 9;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 64;
    localparam int CW       = 10;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          seq_en = 1'b0, seq_we = 1'b0;
    logic [AW-1:0] seq_addr = '0;
    logic [DW-1:0] seq_wdata = '0;
    logic [DW-1:0] seq_rdata;
    logic          seq_rvalid, seq_stall;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid, host_starved;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .seq_en(seq_en), .seq_we(seq_we), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
        .seq_rdata(seq_rdata), .seq_rvalid(seq_rvalid), .seq_stall(seq_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .host_starved(host_starved),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // SRAM macro stand-in: one-cycle registered read
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who gets the port, what data each owner should see, how long the host waited
    typedef struct { int owner; logic [DW-1:0] data; } rd_t;
    rd_t           pend_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] m_seq_last = '0, m_host_last = '0;
    int            m_wait = 0;
    bit            m_starved = 1'b0;
    bit            m_host_gets = 1'b0;

    task automatic cycle(input bit rst,
                         input bit s_en, input bit s_we, input logic [AW-1:0] s_a, input logic [DW-1:0] s_d,
                         input bit h_req, input bit h_we, input logic [AW-1:0] h_a, input logic [DW-1:0] h_d);
        rd_t cur;
        bit has_pend, forced, seq_wins, e_srv, e_hrv, e_stall, e_en, e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d, e_srd, e_hrd;
        @(negedge clk);
        reset = rst; seq_en = s_en; seq_we = s_we; seq_addr = s_a; seq_wdata = s_d;
        host_req = h_req; host_we = h_we; host_addr = h_a; host_wdata = h_d;
        #1;
        has_pend = (pend_q.size() > 0);
        cur = '{owner: 0, data: '0};
        if (has_pend) cur = pend_q.pop_front();
        e_srv = !rst && has_pend && cur.owner == 1;
        e_hrv = !rst && has_pend && cur.owner == 2;
        e_srd = rst ? '0 : (e_srv ? cur.data : m_seq_last);
        e_hrd = rst ? '0 : (e_hrv ? cur.data : m_host_last);
        forced      = GUARD && h_req && (m_wait >= MAX_WAIT);
        seq_wins    = !rst && s_en && !forced;
        m_host_gets = !rst && h_req && !seq_wins;
        e_stall     = !rst && s_en && forced;
        e_en = seq_wins || m_host_gets;
        e_we = seq_wins ? s_we : (m_host_gets ? h_we : 1'b0);
        e_a  = seq_wins ? s_a  : (m_host_gets ? h_a  : '0);
        e_d  = seq_wins ? s_d  : (m_host_gets ? h_d  : '0);
        check_eq("mem_en", mem_en, e_en);
        check_eq("mem_we", mem_we, e_we);
        check_eq("mem_addr", mem_addr, e_a);
        check_eq("mem_wdata", mem_wdata, e_d);
        check_eq("host_ack", host_ack, m_host_gets);
        check_eq("seq_stall", seq_stall, e_stall);
        check_eq("seq_rvalid", seq_rvalid, e_srv);
        check_eq("host_rvalid", host_rvalid, e_hrv);
        check_eq("seq_rdata", seq_rdata, e_srd);
        check_eq("host_rdata", host_rdata, e_hrd);
        check_eq("host_starved", host_starved, !rst && m_starved);
        if (rst) begin
            pend_q.delete();
            m_seq_last = '0; m_host_last = '0; m_wait = 0; m_starved = 1'b0;
        end else begin
            if (e_srv) m_seq_last = cur.data;
            if (e_hrv) m_host_last = cur.data;
            if (seq_wins) begin
                if (s_we) ref_mem[s_a] = s_d;
                else pend_q.push_back('{owner: 1, data: ref_mem[s_a]});
            end else if (m_host_gets) begin
                if (h_we) ref_mem[h_a] = h_d;
                else pend_q.push_back('{owner: 2, data: ref_mem[h_a]});
            end
            if (!h_req || m_host_gets) m_wait = 0;
            else if (m_wait < (1 << CW) - 1) m_wait = m_wait + 1;
            m_starved = (m_wait >= MAX_WAIT);
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        bit acked;
        bit h_req_r, h_we_r;
        logic [AW-1:0] h_a_r;
        logic [DW-1:0] h_d_r;
        int dens [6] = '{50, 90, 100, 20, 97, 60};

        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            ref_mem[i] = v;
            sram[i] <= v;
        end
        ref_mem[9'h040] = 16'hBEEF; sram[9'h040] <= 16'hBEEF;
        ref_mem[9'h080] = 16'h1234; sram[9'h080] <= 16'h1234;

        // 1: reset with both requesters active
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 9'h040, 16'h0, 1, 0, 9'h080, 16'h0);
            check_eq("t1_mem_en", mem_en, 0);
            check_eq("t1_host_ack", host_ack, 0);
        end
        $display("phase reset done");

        // 2: sequencer read, host idle
        cycle(0, 1, 0, 9'h040, 16'h0, 0, 0, 9'h000, 16'h0);
        cycle(0, 0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
        check_eq("t2_seq_rvalid", seq_rvalid, 1);
        check_eq("t2_seq_rdata", seq_rdata, 16'hBEEF);
        $display("phase seq read done");

        // 3: collision, host served the cycle after
        cycle(0, 1, 0, 9'h010, 16'h0, 1, 0, 9'h080, 16'h0);
        check_eq("t3_no_ack_on_collision", host_ack, 0);
        cycle(0, 0, 0, 9'h000, 16'h0, 1, 0, 9'h080, 16'h0);
        check_eq("t3_host_ack", host_ack, 1);
        check_eq("t3_seq_rvalid", seq_rvalid, 1);
        cycle(0, 0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
        check_eq("t3_host_rvalid", host_rvalid, 1);
        check_eq("t3_host_rdata", host_rdata, 16'h1234);
        check_eq("t3_seq_rvalid_once", seq_rvalid, 0);
        $display("phase collision done");

        // 4: starvation under continuous sequencer traffic
        acked = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            cycle(0, 1, 0, AW'($urandom), 16'h0, !acked, 0, 9'h100, 16'h0);
            if (k == 64) check_eq("t4_not_starved_64", host_starved, 0);
            if (k == 65) begin
                check_eq("t4_starved_65", host_starved, 1);
                check_eq("t4_ack_65", host_ack, GUARD);
                check_eq("t4_stall_65", seq_stall, GUARD);
            end
            if (k == 66 && GUARD) check_eq("t4_starved_clear_66", host_starved, 0);
            if (!GUARD && k < 70) check_eq("t4_no_ack", host_ack, 0);
            if (m_host_gets) acked = 1'b1;
        end
        cycle(0, 0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
        $display("phase starvation done");

        // 5: alternating seq / host reads
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) cycle(0, 1, 0, AW'($urandom), 16'h0, 0, 0, 9'h000, 16'h0);
            else            cycle(0, 0, 0, 9'h000, 16'h0, 1, 0, AW'($urandom), 16'h0);
        end
        $display("phase alternating done");

        // 6: reset lands on a host read in flight
        cycle(1, 0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
        cycle(0, 0, 0, 9'h000, 16'h0, 1, 0, 9'h080, 16'h0);
        check_eq("t6_host_ack", host_ack, 1);
        cycle(1, 1, 0, 9'h040, 16'h0, 1, 0, 9'h080, 16'h0);
        check_eq("t6_rvalid_in_reset", host_rvalid, 0);
        check_eq("t6_rdata_in_reset", host_rdata, 0);
        check_eq("t6_mem_en_in_reset", mem_en, 0);
        cycle(0, 0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
        check_eq("t6_rvalid_after", host_rvalid, 0);
        check_eq("t6_rdata_after", host_rdata, 0);
        $display("phase reset-in-flight done");

        // Random traffic, host holds its request until acknowledged
        h_req_r = 1'b0; h_we_r = 1'b0; h_a_r = '0; h_d_r = '0;
        for (int seg = 0; seg < 6; seg++) begin
            for (int k = 0; k < 500; k++) begin
                if (!h_req_r || m_host_gets) begin
                    h_req_r = ($urandom_range(0, 3) != 0);
                    h_we_r  = ($urandom_range(0, 9) < 3);
                    h_a_r   = AW'($urandom);
                    h_d_r   = DW'($urandom);
                end
                cycle(($urandom_range(0, 299) == 0),
                      ($urandom_range(0, 99) < dens[seg]), ($urandom_range(0, 9) < 3),
                      AW'($urandom), DW'($urandom),
                      h_req_r, h_we_r, h_a_r, h_d_r);
            end
            $display("random segment %0d density %0d done", seg, dens[seg]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
